// File: rtl/l1_dcache_pkg.sv
// Shared types and helpers for the L1 data cache.
// Optional statistics counters are enabled with DCACHE_STATS_EN (see l1_dcache.sv).
package l1_dcache_pkg;

   typedef logic [127:0] lc3b_line;
   typedef logic [15:0]  lc3b_word;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      FILL
   } dcache_state_t;

   // Merge one 16-bit word into a line under a byte mask; unmasked bytes keep the old line data.
   function automatic lc3b_line merge_word(input lc3b_line line, input logic [2:0] word,
                                           input lc3b_word wdata, input logic [1:0] wmask);
      lc3b_line r;
      r = line;
      if (wmask[0]) r[{word, 4'h0} +: 8] = wdata[7:0];
      if (wmask[1]) r[{word, 4'h8} +: 8] = wdata[15:8];
      return r;
   endfunction

endpackage

// File: rtl/l1_dcache_array.sv
// Per-set register array with combinational read and single write port.
// RESET_CLEAR selects whether reset wipes the contents (valid/dirty) or leaves them (tag/data).
module l1_dcache_array #(
   parameter int WIDTH       = 1,
   parameter int INDEX_BITS  = 3,
   parameter bit RESET_CLEAR = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [INDEX_BITS-1:0] index,
   input  logic [WIDTH-1:0]      in,
   output logic [WIDTH-1:0]      out
);

   logic [WIDTH-1:0] mem_q [2**INDEX_BITS];

   // Write the addressed set on load; clearing arrays are zeroed by reset
   always_ff @(posedge clk) begin
      if (rst && RESET_CLEAR) begin
         for (int i = 0; i < 2**INDEX_BITS; i++) mem_q[i] <= '0;
      end else if (load) begin
         mem_q[index] <= in;
      end
   end

   assign out = mem_q[index];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache (16-bit address, 16-byte lines).
// Zero-wait hits in IDLE; misses go through WRITEBACK (dirty victim) and FILL.
// Define DCACHE_STATS_EN to add hit/miss/writeback counters.
module l1_dcache
   import l1_dcache_pkg::*;
#(
   parameter int INDEX_BITS = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read_d,
   input  logic        mem_write,
   input  logic [15:0] address,
   input  logic [15:0] mem_wdata,
   input  logic [1:0]  wmask,
   output logic [15:0] mem_rdata,
   output logic        mem_resp_d,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic [15:0] pmem_address,
   output lc3b_line    pmem_wdata,
   input  lc3b_line    pmem_rdata,
   input  logic        pmem_resp
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count,
   output logic [15:0] wb_count
`endif
);

   localparam int TAG_BITS = 12 - INDEX_BITS;

   dcache_state_t         state_q;
   logic                  pmem_read_q, pmem_write_q;
   logic [INDEX_BITS-1:0] index;
   logic [TAG_BITS-1:0]   tag, tag_out;
   logic                  valid_out, dirty_out;
   lc3b_line              data_out, data_in;
   logic                  req, hit, miss, wr_hit, fill_done;
   logic                  unused_byte_sel;

   assign index           = address[4 +: INDEX_BITS];
   assign tag             = address[15 -: TAG_BITS];
   assign unused_byte_sel = address[0];

   assign req        = mem_read_d | mem_write;
   assign hit        = valid_out && (tag_out == tag);
   assign mem_resp_d = (state_q == IDLE) && req && hit;
   assign miss       = (state_q == IDLE) && req && !hit;
   // A simultaneous read+write is treated as a write
   assign wr_hit     = mem_resp_d && mem_write;
   assign fill_done  = (state_q == FILL) && pmem_resp;

   assign mem_rdata = data_out[{address[3:1], 4'h0} +: 16];
   assign data_in   = fill_done ? pmem_rdata : merge_word(data_out, address[3:1], mem_wdata, wmask);

   l1_dcache_array #(.WIDTH(1), .INDEX_BITS(INDEX_BITS), .RESET_CLEAR(1'b1)) u_valid (
      .clk(clk), .rst(rst), .load(fill_done), .index(index), .in(1'b1), .out(valid_out));

   // Fill clears dirty, write hit sets it; the two never coincide
   l1_dcache_array #(.WIDTH(1), .INDEX_BITS(INDEX_BITS), .RESET_CLEAR(1'b1)) u_dirty (
      .clk(clk), .rst(rst), .load(fill_done | wr_hit), .index(index), .in(wr_hit), .out(dirty_out));

   l1_dcache_array #(.WIDTH(TAG_BITS), .INDEX_BITS(INDEX_BITS), .RESET_CLEAR(1'b0)) u_tag (
      .clk(clk), .rst(rst), .load(fill_done), .index(index), .in(tag), .out(tag_out));

   l1_dcache_array #(.WIDTH(128), .INDEX_BITS(INDEX_BITS), .RESET_CLEAR(1'b0)) u_data (
      .clk(clk), .rst(rst), .load(fill_done | wr_hit), .index(index), .in(data_in), .out(data_out));

   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = (state_q == WRITEBACK) ? {tag_out, index, 4'h0} : {address[15:4], 4'h0};
   assign pmem_wdata   = data_out;

   // Miss-handling FSM; pmem strobes are registered alongside the state so they are pure Moore outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (miss) begin
               if (valid_out && dirty_out) begin
                  state_q      <= WRITEBACK;
                  pmem_write_q <= 1'b1;
               end else begin
                  state_q     <= FILL;
                  pmem_read_q <= 1'b1;
               end
            end
            WRITEBACK: if (pmem_resp) begin
               state_q      <= FILL;
               pmem_write_q <= 1'b0;
               pmem_read_q  <= 1'b1;
            end
            FILL: if (pmem_resp) begin
               state_q     <= IDLE;
               pmem_read_q <= 1'b0;
            end
            default: begin
               state_q      <= IDLE;
               pmem_read_q  <= 1'b0;
               pmem_write_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic        missed_q;
   logic [15:0] hit_q, miss_q, wb_q;

   // Event counters; a response only counts as a hit if its request never missed
   always_ff @(posedge clk) begin
      if (rst) begin
         missed_q <= 1'b0;
         hit_q    <= '0;
         miss_q   <= '0;
         wb_q     <= '0;
      end else begin
         if (miss) begin
            miss_q   <= miss_q + 16'd1;
            missed_q <= 1'b1;
         end
         if ((state_q == WRITEBACK) && pmem_resp) wb_q <= wb_q + 16'd1;
         if (mem_resp_d) begin
            missed_q <= 1'b0;
            if (!missed_q) hit_q <= hit_q + 16'd1;
         end
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
   assign wb_count   = wb_q;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: directed vector table, reset-abort sequence,
// and randomized requests against a set/line-level cache and memory model.
module tb_l1_dcache;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_read_d, mem_write;
   logic [15:0]  address, mem_wdata;
   logic [1:0]   wmask;
   logic [15:0]  mem_rdata;
   logic         mem_resp_d;
   logic         pmem_read, pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;
`ifdef DCACHE_STATS_EN
   logic [15:0]  hit_count, miss_count, wb_count;
`endif

   int total = 0;
   int bad   = 0;

   l1_dcache dut (
      .clk(clk), .rst(rst), .mem_read_d(mem_read_d), .mem_write(mem_write),
      .address(address), .mem_wdata(mem_wdata), .wmask(wmask),
      .mem_rdata(mem_rdata), .mem_resp_d(mem_resp_d),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef DCACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: 8 sets, 9-bit tags, plus a sparse backing memory
   logic         m_valid [8];
   logic         m_dirty [8];
   logic [8:0]   m_tag   [8];
   logic [127:0] m_data  [8];
   logic [127:0] mem_m [logic [15:0]];
   int exp_hits = 0, exp_misses = 0, exp_wbs = 0;

   typedef enum {P_CMP, P_WB, P_FILL, P_HIT} ph_t;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] a;
      logic [15:0] wd;
      logic [1:0]  wm;
      logic        chk;
      logic [15:0] exp;
      logic        miss;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] mem_line(input logic [15:0] la);
      logic [127:0] l;
      if (mem_m.exists(la)) return mem_m[la];
      for (int i = 0; i < 8; i++) l[i*16 +: 16] = {la[15:4], 4'(i)} ^ 16'hC3A5;
      return l;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      exp_hits = 0; exp_misses = 0; exp_wbs = 0;
   endtask

   task automatic chk_stats();
`ifdef DCACHE_STATS_EN
      chk("hit_count", 128'(hit_count), 128'(exp_hits));
      chk("miss_count", 128'(miss_count), 128'(exp_misses));
      chk("wb_count", 128'(wb_count), 128'(exp_wbs));
`endif
   endtask

   // One request from the pipeline side, servicing pmem with random latency.
   // Called at a negedge; returns at a negedge with the request dropped.
   task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                      input logic [1:0] wm, output logic [15:0] rdata_o, output logic missed);
      int          idx;
      logic [8:0]  tg;
      logic [15:0] la;
      ph_t         ph;
      int          waitn;
      bit          done;
      logic [2:0]  exp_s;
      logic [15:0] w;
      idx = int'(a[6:4]);
      tg  = a[15:7];
      la  = {a[15:4], 4'h0};
      ph  = (m_valid[idx] && m_tag[idx] == tg) ? P_HIT : P_CMP;
      missed = (ph != P_HIT);
      rdata_o = '0;
      mem_read_d = rd; mem_write = wr; address = a; mem_wdata = wd; wmask = wm;
      waitn = $urandom_range(0, 2);
      done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         case (ph)
            P_CMP:   exp_s = 3'b000;
            P_WB:    exp_s = 3'b010;
            P_FILL:  exp_s = 3'b001;
            default: exp_s = 3'b100;
         endcase
         chk("resp_wr_rd", 128'({mem_resp_d, pmem_write, pmem_read}), 128'(exp_s));
         pmem_resp = 1'b0;
         case (ph)
            P_CMP: begin
               exp_misses++;
               if (m_valid[idx] && m_dirty[idx]) begin
                  ph = P_WB;
                  exp_wbs++;
               end else ph = P_FILL;
            end
            P_WB: begin
               chk("wb_addr", 128'(pmem_address), 128'({m_tag[idx], 3'(idx), 4'h0}));
               chk("wb_data", pmem_wdata, m_data[idx]);
               if (waitn == 0) begin
                  pmem_resp = 1'b1;
                  mem_m[{m_tag[idx], 3'(idx), 4'h0}] = m_data[idx];
                  m_dirty[idx] = 1'b0;
                  ph = P_FILL;
                  waitn = $urandom_range(0, 2);
               end else waitn--;
            end
            P_FILL: begin
               chk("fill_addr", 128'(pmem_address), 128'(la));
               if (waitn == 0) begin
                  pmem_resp  = 1'b1;
                  pmem_rdata = mem_line(la);
                  m_valid[idx] = 1'b1;
                  m_dirty[idx] = 1'b0;
                  m_tag[idx]   = tg;
                  m_data[idx]  = pmem_rdata;
                  ph = P_HIT;
               end else waitn--;
            end
            default: begin
               rdata_o = mem_rdata;
               w = m_data[idx][{a[3:1], 4'h0} +: 16];
               if (rd && !wr) chk("rdata", 128'(mem_rdata), 128'(w));
               if (!missed) exp_hits++;
               if (wr) begin
                  if (wm[0]) m_data[idx][{a[3:1], 4'h0} +: 8] = wd[7:0];
                  if (wm[1]) m_data[idx][{a[3:1], 4'h8} +: 8] = wd[15:8];
                  m_dirty[idx] = 1'b1;
               end
               done = 1;
            end
         endcase
         @(negedge clk);
      end
      if (!done) chk("req_timeout", 128'(0), 128'(1));
      pmem_resp = 1'b0;
      mem_read_d = 1'b0; mem_write = 1'b0;
      chk_stats();
   endtask

   vec_t        tbl [12];
   logic [15:0] rd_v;
   logic        ms;

   initial begin
      rst = 1'b1; mem_read_d = 1'b0; mem_write = 1'b0; address = '0; mem_wdata = '0;
      wmask = '0; pmem_rdata = '0; pmem_resp = 1'b0;
      model_reset();
      mem_m[16'h1230] = 128'h7777_6666_5555_4444_3C3C_5A5A_1111_0101;
      mem_m[16'h1330] = 128'hF7F7_F6F6_F5F5_F4F4_F3F3_7E7E_F1F1_F0F0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_pmem_read", 128'(pmem_read), 128'(0));
      chk("reset_pmem_write", 128'(pmem_write), 128'(0));
      chk("reset_resp", 128'(mem_resp_d), 128'(0));
      chk_stats();
      @(negedge clk);

      //         rd    wr    addr      wdata     wm     chk   exp       miss
      tbl[0]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 1'b1, 16'h5A5A, 1'b1};
      tbl[1]  = '{1'b1, 1'b0, 16'h1236, 16'h0000, 2'b00, 1'b1, 16'h3C3C, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 16'h1235, 16'hAB00, 2'b10, 1'b0, 16'h0000, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 1'b1, 16'hAB5A, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 16'h1230, 16'hFFFF, 2'b00, 1'b0, 16'h0000, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 16'h1230, 16'h0000, 2'b00, 1'b1, 16'h0101, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 16'h1230, 16'h12EE, 2'b01, 1'b0, 16'h0000, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 16'h1232, 16'hBEEF, 2'b11, 1'b0, 16'h0000, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 16'h1232, 16'h0000, 2'b00, 1'b1, 16'hBEEF, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 16'h1230, 16'h0000, 2'b00, 1'b1, 16'h01EE, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 16'h1334, 16'h0000, 2'b00, 1'b1, 16'h7E7E, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, 1'b1, 16'hAB5A, 1'b1};

      for (int i = 0; i < 12; i++) begin
         req(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].wm, rd_v, ms);
         chk($sformatf("vec%0d_miss", i), 128'(ms), 128'(tbl[i].miss));
         if (tbl[i].chk) chk($sformatf("vec%0d_rdata", i), 128'(rd_v), 128'(tbl[i].exp));
      end

      // Reset during FILL aborts the transfer and invalidates everything
      address = 16'h5678; mem_read_d = 1'b1;
      @(negedge clk); #1;
      chk("abort_pmem_read_on", 128'(pmem_read), 128'(1));
      chk("abort_fill_addr", 128'(pmem_address), 128'(16'h5670));
      rst = 1'b1; mem_read_d = 1'b0;
      @(negedge clk); #1;
      chk("abort_pmem_read_off", 128'(pmem_read), 128'(0));
      chk("abort_pmem_write_off", 128'(pmem_write), 128'(0));
      rst = 1'b0;
      model_reset();
      chk_stats();
      @(negedge clk);
      req(1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, rd_v, ms);
      chk("reread_after_reset_miss", 128'(ms), 128'(1));
      chk("reread_after_reset_data", 128'(rd_v), 128'(16'hAB5A));

      // Random traffic over 4 tags x 8 sets to provoke hits, conflicts and writebacks
      for (int n = 0; n < 400; n++) begin
         logic [15:0] a;
         int          k;
         a = 16'($urandom);
         a[15:7] = 9'($urandom_range(0, 3));
         k = $urandom_range(0, 9);
         req(k <= 4 || k == 9, k >= 5, a, 16'($urandom), 2'($urandom), rd_v, ms);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
